// File: rtl/sha256_host_ctrl_pkg.sv
// Shared types and default constants for the SHA-256 host controller.
// Optional watchdog is enabled by defining SHA_CTRL_TIMEOUT_EN.
package sha256_ctrl_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    START     = 3'd2,
    WAIT_BUSY = 3'd3,
    WAIT_DONE = 3'd4,
    FETCH     = 3'd5,
    RDWAIT    = 3'd6,
    DRAIN     = 3'd7
  } state_t;

  localparam logic [15:0] DEF_MSG_BASE = 16'h0000;
  localparam logic [15:0] DEF_OUT_BASE = 16'h0100;

endpackage

// File: rtl/sha256_host_ctrl_if.sv
// Message-in / hash-out valid/ready streams of the SHA-256 host controller.
// "slave" is the controller side, "master" is the producer/consumer side.
interface sha256_host_ctrl_if;
  import sha256_ctrl_pkg::*;

  logic  in_valid;
  logic  in_ready;
  word_t in_data;
  logic  out_valid;
  logic  out_ready;
  word_t out_data;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

endinterface

// File: rtl/sha256_host_ctrl.sv
// Host-side driver for simplified_sha256: loads the message into shared
// word memory, kicks the hasher, waits for it and streams the hash back.
// Define SHA_CTRL_TIMEOUT_EN to add a sticky watchdog on the hasher wait.
//
// state     | meaning
// IDLE      | ready for the first message word
// LOAD      | writing the remaining message words
// START     | last write lands; hand memory to hasher, pulse start
// WAIT_BUSY | waiting for hasher to drop done
// WAIT_DONE | waiting for hasher to raise done again
// FETCH     | hash word address on the memory port
// RDWAIT    | read data arriving, capture into out_data
// DRAIN     | holding out_data until the consumer takes it
module sha256_host_ctrl
  import sha256_ctrl_pkg::*;
#(
  parameter int          NUM_OF_WORDS = 20,
  parameter int          HASH_WORDS   = 8,
  parameter logic [15:0] MSG_BASE     = DEF_MSG_BASE,
  parameter logic [15:0] OUT_BASE     = DEF_OUT_BASE
`ifdef SHA_CTRL_TIMEOUT_EN
  , parameter int        TIMEOUT_CYCLES = 4096
`endif
) (
  input  logic                      clk,
  input  logic                      reset_n,
  sha256_host_ctrl_if.slave         strm,
  output logic                      core_start,
  input  logic                      core_done,
  output logic [15:0]               message_addr,
  output logic [15:0]               output_addr,
  output logic                      mem_grant,
  output logic                      mem_we,
  output logic [15:0]               mem_addr,
  output word_t                     mem_write_data,
  input  word_t                     mem_read_data,
  output logic                      busy,
  output logic                      error
);

  localparam int CNT_MAX = (NUM_OF_WORDS > HASH_WORDS) ? NUM_OF_WORDS : HASH_WORDS;
  localparam int CW      = $clog2(CNT_MAX) + 1;
  localparam logic [CW-1:0] LAST_MSG  = CW'(NUM_OF_WORDS - 1);
  localparam logic [CW-1:0] LAST_HASH = CW'(HASH_WORDS - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          in_ready_q;
  logic          out_valid_q;
  word_t         out_data_q;

`ifdef SHA_CTRL_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);
  logic [WDW-1:0] wd_cnt;
  logic           error_q;
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  assign message_addr  = MSG_BASE;
  assign output_addr   = OUT_BASE;
  assign busy          = (state != IDLE);
  assign strm.in_ready  = in_ready_q;
  assign strm.out_valid = out_valid_q;
  assign strm.out_data  = out_data_q;

  // Job sequencer: all outputs registered; mem_we and core_start default low each cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      cnt            <= '0;
      in_ready_q     <= 1'b0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      core_start     <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      mem_grant      <= 1'b1;
`ifdef SHA_CTRL_TIMEOUT_EN
      wd_cnt         <= '0;
      error_q        <= 1'b0;
`endif
    end else begin
      core_start <= 1'b0;
      mem_we     <= 1'b0;
      case (state)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (strm.in_valid && in_ready_q) begin
            mem_we         <= 1'b1;
            mem_addr       <= MSG_BASE;
            mem_write_data <= strm.in_data;
            cnt            <= CW'(1);
            state          <= LOAD;
          end
        end
        LOAD: begin
          if (strm.in_valid && in_ready_q) begin
            mem_we         <= 1'b1;
            mem_addr       <= MSG_BASE + 16'(cnt);
            mem_write_data <= strm.in_data;
            cnt            <= cnt + 1'b1;
            if (cnt == LAST_MSG) begin
              in_ready_q <= 1'b0;
              state      <= START;
            end
          end
        end
        // The final message write is on the bus during this cycle, so the
        // memory is handed over only at its end.
        START: begin
          mem_grant  <= 1'b0;
          core_start <= 1'b1;
          state      <= WAIT_BUSY;
`ifdef SHA_CTRL_TIMEOUT_EN
          wd_cnt     <= '0;
`endif
        end
        WAIT_BUSY: begin
          if (!core_done) state <= WAIT_DONE;
        end
        // Address goes out on entry so FETCH carries it and RDWAIT sees data.
        WAIT_DONE: begin
          if (core_done) begin
            mem_grant <= 1'b1;
            cnt       <= '0;
            mem_addr  <= OUT_BASE;
            state     <= FETCH;
          end
        end
        FETCH: begin
          state <= RDWAIT;
        end
        RDWAIT: begin
          out_data_q  <= mem_read_data;
          out_valid_q <= 1'b1;
          state       <= DRAIN;
        end
        DRAIN: begin
          if (strm.out_ready) begin
            out_valid_q <= 1'b0;
            cnt         <= cnt + 1'b1;
            if (cnt == LAST_HASH) begin
              in_ready_q <= 1'b1;
              state      <= IDLE;
            end else begin
              mem_addr <= OUT_BASE + 16'(cnt + 1'b1);
              state    <= FETCH;
            end
          end
        end
        default: state <= IDLE;
      endcase
`ifdef SHA_CTRL_TIMEOUT_EN
      // Watchdog overrides the wait states: abandon the job, reclaim memory.
      if (state == WAIT_BUSY || state == WAIT_DONE) begin
        if (wd_cnt == WD_LAST) begin
          error_q    <= 1'b1;
          mem_grant  <= 1'b1;
          in_ready_q <= 1'b1;
          state      <= IDLE;
        end else begin
          wd_cnt <= wd_cnt + 1'b1;
        end
      end
`endif
    end
  end

endmodule
